cpu_memory_arbiter: RTL

CPU_MEMORY_ARBITER -- requirements
Module: cpu_memory_arbiter

---
 rtl/cpu_memory_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_memory_arbiter.sv
// Round-robin arbiter sharing one backing memory between an instruction-cache read port
// and a data read/write port; one transaction in flight, fixed memory read latency.

module cpu_memory_arbiter_checker (
    input logic CLK,
    input logic RSTb,
    input logic instr_memory_valid,
    input logic data_memory_valid,
    input logic mem_rd,
    input logic mem_wr
);

    // strobes and responses are single-cycle pulses and never overlap
    property p_single_pulse(logic sig);
        @(posedge CLK) disable iff (!RSTb) sig |=> !sig;
    endproperty

    a_rd_pulse: assert property (p_single_pulse(mem_rd));
    a_wr_pulse: assert property (p_single_pulse(mem_wr));
    a_iv_pulse: assert property (p_single_pulse(instr_memory_valid));
    a_dv_pulse: assert property (p_single_pulse(data_memory_valid));
    a_rw_excl:  assert property (@(posedge CLK) disable iff (!RSTb) !(mem_rd && mem_wr));
    a_v_excl:   assert property (@(posedge CLK) disable iff (!RSTb)
                                 !(instr_memory_valid && data_memory_valid));

endmodule

module cpu_memory_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        instr_memory_ready,
    input  logic [15:0] instr_memory_address,
    output logic        instr_memory_valid,
    output logic [15:0] instr_memory_data,
    input  logic        data_memory_ready,
    input  logic        data_memory_wr,
    input  logic [15:0] data_memory_address,
    input  logic [15:0] data_memory_wr_data,
    input  logic [1:0]  data_memory_wr_mask,
    output logic        data_memory_valid,
    output logic [15:0] data_memory_data,
    output logic [15:0] mem_address,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wr_data,
    output logic [1:0]  mem_wr_mask,
    input  logic [15:0] mem_data_in
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C = 4'(MEM_LATENCY);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        grant_data_r;
    logic        last_grant_data_r;
    logic        txn_wr_r;
    logic [3:0]  cnt_r;
    logic [15:0] rd_data_r;
    logic        any_req_s;
    logic        pick_data_s;
    logic        wr_sel_s;
    logic        grant_s;
    logic        capture_s;

    // round-robin pick: data wins only if instruction is idle or was served last
    always_comb begin
        any_req_s   = instr_memory_ready | data_memory_ready;
        pick_data_s = data_memory_ready & (~instr_memory_ready | ~last_grant_data_r);
        wr_sel_s    = pick_data_s & data_memory_wr;
        grant_s     = (state_r == ST_IDLE) & any_req_s;
    end

    // next-state and capture decode
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_STROBE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (txn_wr_r) begin
                    state_nxt_s = ST_RESPOND;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a zero count can only come from corruption; leave rather than stall
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_RESPOND;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESPOND: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // transaction fields latched at grant; later input changes are ignored
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            grant_data_r      <= 1'b0;
            last_grant_data_r <= 1'b1;
            txn_wr_r          <= 1'b0;
            mem_address       <= 16'h0000;
            mem_wr_data       <= 16'h0000;
            mem_wr_mask       <= 2'b00;
        end else if (grant_s) begin
            grant_data_r      <= pick_data_s;
            last_grant_data_r <= pick_data_s;
            txn_wr_r          <= wr_sel_s;
            mem_address       <= pick_data_s ? data_memory_address : instr_memory_address;
            mem_wr_data       <= wr_sel_s ? data_memory_wr_data : 16'h0000;
            mem_wr_mask       <= wr_sel_s ? data_memory_wr_mask : 2'b00;
        end
    end

    // latency counter and read-data register
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            cnt_r     <= 4'd0;
            rd_data_r <= 16'h0000;
        end else begin
            if ((state_r == ST_STROBE) && !txn_wr_r) begin
                cnt_r <= LAT_C;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (capture_s) begin
                rd_data_r <= mem_data_in;
            end
        end
    end

    // pulse outputs are registered from the upcoming state so they align with it
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            mem_rd             <= 1'b0;
            mem_wr             <= 1'b0;
            instr_memory_valid <= 1'b0;
            data_memory_valid  <= 1'b0;
        end else begin
            mem_rd             <= grant_s & ~wr_sel_s;
            mem_wr             <= grant_s & wr_sel_s;
            instr_memory_valid <= (state_nxt_s == ST_RESPOND) & ~grant_data_r;
            data_memory_valid  <= (state_nxt_s == ST_RESPOND) & grant_data_r;
        end
    end

    assign instr_memory_data = rd_data_r;
    assign data_memory_data  = rd_data_r;

    cpu_memory_arbiter_checker u_checker (
        .CLK                (CLK),
        .RSTb               (RSTb),
        .instr_memory_valid (instr_memory_valid),
        .data_memory_valid  (data_memory_valid),
        .mem_rd             (mem_rd),
        .mem_wr             (mem_wr)
    );

endmodule
